// File: rtl/uart_packet_to_tilelink.sv
`default_nettype none
// ============================================================================
// Module  : uart_packet_to_tilelink
// Brief   : Packs 16-byte UART packets into one TileLink serializer frame.
//           Optional macro UART_TL_TIMEOUT_EN adds a partial-packet idle timeout.
// Revision: 1.0 - initial release
// ============================================================================
module uart_packet_to_tilelink #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        async_reset_n,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tl_in_valid,
  input  logic        tl_in_ready,
  output logic [2:0]  tl_in_bits_chanId,
  output logic [2:0]  tl_in_bits_opcode,
  output logic [2:0]  tl_in_bits_param,
  output logic [7:0]  tl_in_bits_size,
  output logic [7:0]  tl_in_bits_source,
  output logic [63:0] tl_in_bits_address,
  output logic [63:0] tl_in_bits_data,
  output logic        tl_in_bits_corrupt,
  output logic [8:0]  tl_in_bits_union,
  output logic [7:0]  timeout_count
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_rx_ready;
  logic        r_tl_valid;
  logic [3:0]  r_byte_cnt;

  // Fields of the packet being collected; byte 15 goes straight to the frame.
  logic [2:0]  r_stg_chan;
  logic [2:0]  r_stg_opcode;
  logic [2:0]  r_stg_param;
  logic        r_stg_corrupt;
  logic [7:0]  r_stg_size;
  logic [7:0]  r_stg_union;
  logic [31:0] r_stg_addr;
  logic [55:0] r_stg_data;

  logic        w_accept;
  logic        w_timeout;
  logic [3:0]  w_wr_idx;

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_check_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  assign w_accept = rx_valid & r_rx_ready;
  // A byte arriving in the timeout cycle starts a fresh packet.
  assign w_wr_idx = w_timeout ? 4'd0 : r_byte_cnt;

`ifdef UART_TL_TIMEOUT_EN
  localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_IDLE_W-1:0] c_TIMEOUT = c_IDLE_W'(TIMEOUT_CYCLES);

  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic [7:0]          r_timeout_count;

  assign w_timeout = (r_state == COLLECT) && (r_byte_cnt != 4'd0) && (r_idle_cnt == c_TIMEOUT);

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_idle_cnt      <= '0;
      r_timeout_count <= 8'h00;
    end else if (w_timeout) begin
      r_idle_cnt <= '0;
      if (r_timeout_count != 8'hFF) r_timeout_count <= r_timeout_count + 8'h01;
    end else if (w_accept || (r_state != COLLECT) || (r_byte_cnt == 4'd0)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign timeout_count = r_timeout_count;
`else
  assign w_timeout     = 1'b0;
  assign timeout_count = 8'h00;
`endif

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_state            <= COLLECT;
      r_rx_ready         <= 1'b0;
      r_tl_valid         <= 1'b0;
      r_byte_cnt         <= 4'd0;
      r_stg_chan         <= 3'd0;
      r_stg_opcode       <= 3'd0;
      r_stg_param        <= 3'd0;
      r_stg_corrupt      <= 1'b0;
      r_stg_size         <= 8'h00;
      r_stg_union        <= 8'h00;
      r_stg_addr         <= 32'h0;
      r_stg_data         <= 56'h0;
      tl_in_bits_chanId  <= 3'd0;
      tl_in_bits_opcode  <= 3'd0;
      tl_in_bits_param   <= 3'd0;
      tl_in_bits_size    <= 8'h00;
      tl_in_bits_address <= 64'h0;
      tl_in_bits_data    <= 64'h0;
      tl_in_bits_corrupt <= 1'b0;
      tl_in_bits_union   <= 9'h000;
    end else begin
      case (r_state)
        COLLECT: begin
          r_rx_ready <= 1'b1;
          if (w_timeout) r_byte_cnt <= 4'd0;
          if (w_accept) begin
            r_byte_cnt <= w_wr_idx + 4'd1;
            case (w_wr_idx)
              4'd0: r_stg_chan <= rx_data[2:0];
              4'd1: begin
                r_stg_opcode  <= rx_data[2:0];
                r_stg_param   <= rx_data[6:4];
                r_stg_corrupt <= rx_data[7];
              end
              4'd2: r_stg_size  <= rx_data;
              4'd3: r_stg_union <= rx_data;
              4'd4, 4'd5, 4'd6, 4'd7:
                r_stg_addr[{w_wr_idx[1:0], 3'b000} +: 8] <= rx_data;
              4'd15: begin
                tl_in_bits_chanId  <= r_stg_chan;
                tl_in_bits_opcode  <= r_stg_opcode;
                tl_in_bits_param   <= r_stg_param;
                tl_in_bits_corrupt <= r_stg_corrupt;
                tl_in_bits_size    <= r_stg_size;
                tl_in_bits_union   <= {1'b0, r_stg_union};
                tl_in_bits_address <= {32'h0, r_stg_addr};
                tl_in_bits_data    <= {rx_data, r_stg_data};
                r_tl_valid         <= 1'b1;
                r_rx_ready         <= 1'b0;
                r_state            <= PRESENT;
              end
              default: r_stg_data[{w_wr_idx[2:0], 3'b000} +: 8] <= rx_data;
            endcase
          end
        end
        PRESENT: begin
          if (tl_in_ready) begin
            r_tl_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign rx_ready          = r_rx_ready;
  assign tl_in_valid       = r_tl_valid;
  assign tl_in_bits_source = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_to_tilelink.sv
`default_nettype none
// Testbench for uart_packet_to_tilelink: scoreboard of expected frames checked
// at the frame handshake, plus per-scenario timing and reset checks.
module tb_uart_packet_to_tilelink;

  localparam int TIMEOUT_CYCLES = 20;

  typedef logic [7:0] pkt_t [16];
  typedef struct packed {
    logic [2:0]  chan;
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [7:0]  size;
    logic [7:0]  source;
    logic [63:0] addr;
    logic [63:0] data;
    logic        corrupt;
    logic [8:0]  uni;
  } frame_t;

  logic        clk = 1'b0;
  logic        async_reset_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        tl_in_valid;
  logic        tl_in_ready = 1'b0;
  logic [2:0]  tl_in_bits_chanId, tl_in_bits_opcode, tl_in_bits_param;
  logic [7:0]  tl_in_bits_size, tl_in_bits_source;
  logic [63:0] tl_in_bits_address, tl_in_bits_data;
  logic        tl_in_bits_corrupt;
  logic [8:0]  tl_in_bits_union;
  logic [7:0]  timeout_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;
  int cyc      = 0;
  frame_t exp_q[$];
  int     frame_cyc[$];
  frame_t dut_frame;

  uart_packet_to_tilelink #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk                (clk),
    .async_reset_n      (async_reset_n),
    .rx_valid           (rx_valid),
    .rx_ready           (rx_ready),
    .rx_data            (rx_data),
    .tl_in_valid        (tl_in_valid),
    .tl_in_ready        (tl_in_ready),
    .tl_in_bits_chanId  (tl_in_bits_chanId),
    .tl_in_bits_opcode  (tl_in_bits_opcode),
    .tl_in_bits_param   (tl_in_bits_param),
    .tl_in_bits_size    (tl_in_bits_size),
    .tl_in_bits_source  (tl_in_bits_source),
    .tl_in_bits_address (tl_in_bits_address),
    .tl_in_bits_data    (tl_in_bits_data),
    .tl_in_bits_corrupt (tl_in_bits_corrupt),
    .tl_in_bits_union   (tl_in_bits_union),
    .timeout_count      (timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dut_frame = '{chan: tl_in_bits_chanId, opcode: tl_in_bits_opcode, param: tl_in_bits_param,
                       size: tl_in_bits_size, source: tl_in_bits_source, addr: tl_in_bits_address,
                       data: tl_in_bits_data, corrupt: tl_in_bits_corrupt, uni: tl_in_bits_union};

  function automatic frame_t model(input pkt_t b);
    frame_t f;
    f.chan    = b[0][2:0];
    f.opcode  = b[1][2:0];
    f.param   = b[1][6:4];
    f.corrupt = b[1][7];
    f.size    = b[2];
    f.uni     = {1'b0, b[3]};
    f.addr    = {32'h0, b[7], b[6], b[5], b[4]};
    f.data    = {b[15], b[14], b[13], b[12], b[11], b[10], b[9], b[8]};
    f.source  = 8'h00;
    return f;
  endfunction

  // Scoreboard: every completed handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (async_reset_n && tl_in_valid && tl_in_ready) begin
      frame_t e;
      n_frames++;
      frame_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame_unexpected: got frame %h, expected no frame", dut_frame);
      end else begin
        e = exp_q.pop_front();
        if (dut_frame !== e)
          $display("FAIL frame_fields: got %h, expected %h", dut_frame, e);
        else
          n_pass++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!done) begin
      @(negedge clk);
      done = rx_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        n_checks++;
        $display("FAIL byte_accept_timeout: rx_ready stayed 0 for %0d cycles, expected 1", n);
        done = 1'b1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input pkt_t p);
    exp_q.push_back(model(p));
    for (int i = 0; i < 16; i++) send_byte(p[i]);
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    for (int i = 0; i < 16; i++) p[i] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  task automatic test_reset();
    #1 async_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tl_in_valid, rx_ready, timeout_count, dut_frame} !== '0)
      $display("FAIL reset_state: valid=%b rx_ready=%b tcount=%h frame=%h, expected all 0",
               tl_in_valid, rx_ready, timeout_count, dut_frame);
    else n_pass++;
    async_reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b, expected 1", rx_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    pkt_t p = '{8'h03, 8'hA1, 8'h03, 8'hFF, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    frame_t lit = '{chan: 3'd3, opcode: 3'd1, param: 3'd2, size: 8'h03, source: 8'h00,
                    addr: 64'h12345678, data: 64'h0123456789ABCDEF, corrupt: 1'b1, uni: 9'h0FF};
    tl_in_ready = 1'b1;
    send_packet(p);
    n_checks++;
    if ({tl_in_valid, rx_ready} !== 2'b10)
      $display("FAIL decode_valid_rise: valid,rx_ready=%b, expected 10", {tl_in_valid, rx_ready});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({tl_in_valid, rx_ready} !== 2'b01)
      $display("FAIL decode_valid_fall: valid,rx_ready=%b, expected 01", {tl_in_valid, rx_ready});
    else n_pass++;
    n_checks++;
    if (dut_frame !== lit)
      $display("FAIL decode_retained: got %h, expected %h", dut_frame, lit);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    pkt_t p1 = rand_pkt();
    pkt_t p2 = rand_pkt();
    frame_t held;
    tl_in_ready = 1'b0;
    send_packet(p1);
    held = dut_frame;
    rx_valid = 1'b1;
    rx_data  = p2[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tl_in_valid, rx_ready, dut_frame} !== {1'b1, 1'b0, held})
        $display("FAIL stall_hold_%0d: valid=%b rx_ready=%b frame=%h, expected 1 0 %h",
                 i, tl_in_valid, rx_ready, dut_frame, held);
      else n_pass++;
    end
    @(posedge clk); #1;
    tl_in_ready = 1'b1;
    send_packet(p2);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int f0 = n_frames;
    tl_in_ready = 1'b1;
    frame_cyc.delete();
    for (int k = 0; k < 3; k++) send_packet(rand_pkt());
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (n_frames - f0 !== 3) $display("FAIL stream_count: got %0d frames, expected 3", n_frames - f0);
    else n_pass++;
    for (int k = 1; k < 3 && k < frame_cyc.size(); k++) begin
      n_checks++;
      if (frame_cyc[k] - frame_cyc[k-1] !== 17)
        $display("FAIL stream_spacing_%0d: got %0d cycles, expected 17", k, frame_cyc[k] - frame_cyc[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    pkt_t junk = rand_pkt();
    int c0, f0;
    tl_in_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(junk[i]);
    #2;
    c0 = cyc;
    async_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tl_in_valid, rx_ready, timeout_count, dut_frame} !== '0 || cyc !== c0)
      $display("FAIL async_clear: valid=%b rx_ready=%b frame=%h edges=%0d, expected all 0 and 0 edges",
               tl_in_valid, rx_ready, dut_frame, cyc - c0);
    else n_pass++;
    #2 async_reset_n = 1'b1;
    f0 = n_frames;
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (n_frames !== f0 || tl_in_valid !== 1'b0)
      $display("FAIL reset_no_frame: frames=%0d valid=%b, expected 0 frames valid 0", n_frames - f0, tl_in_valid);
    else n_pass++;
    send_packet(rand_pkt());
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (n_frames - f0 !== 1) $display("FAIL reset_recover: got %0d frames, expected 1", n_frames - f0);
    else n_pass++;
  endtask

`ifdef UART_TL_TIMEOUT_EN
  task automatic test_timeout();
    pkt_t junk = rand_pkt();
    int f0 = n_frames;
    tl_in_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(junk[i]);
    repeat (TIMEOUT_CYCLES) @(posedge clk);
    #1;
    send_packet(rand_pkt());
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (timeout_count !== 8'd1) $display("FAIL timeout_count: got %0d, expected 1", timeout_count);
    else n_pass++;
    n_checks++;
    if (n_frames - f0 !== 1) $display("FAIL timeout_frames: got %0d, expected 1", n_frames - f0);
    else n_pass++;
  endtask
`else
  task automatic test_macro_off();
    pkt_t p = rand_pkt();
    int f0 = n_frames;
    tl_in_ready = 1'b1;
    exp_q.push_back(model(p));
    for (int i = 0; i < 5; i++) send_byte(p[i]);
    repeat (5000) @(posedge clk);
    #1;
    n_checks++;
    if (n_frames !== f0 || tl_in_valid !== 1'b0)
      $display("FAIL idle_no_frame: frames=%0d valid=%b, expected 0 frames valid 0", n_frames - f0, tl_in_valid);
    else n_pass++;
    for (int i = 5; i < 16; i++) send_byte(p[i]);
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (n_frames - f0 !== 1) $display("FAIL idle_frames: got %0d, expected 1", n_frames - f0);
    else n_pass++;
    n_checks++;
    if (timeout_count !== 8'd0) $display("FAIL idle_timeout_count: got %0d, expected 0", timeout_count);
    else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_back_to_back();
`ifdef UART_TL_TIMEOUT_EN
    test_timeout();
`else
    test_macro_off();
`endif
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL frames_outstanding: got %0d missing, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_packet_to_tilelink.md
UART_PACKET_TO_TILELINK -- requirements
Module: uart_packet_to_tilelink

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, the idle clk cycles allowed between bytes of one packet.
REQ-002 SHALL have ports clk (input, 1, sole clock) and async_reset_n (input, 1, asynchronous active-low reset); all logic is in the clk domain.
REQ-003 SHALL have rx_valid (input, 1), rx_ready (output, 1) and rx_data (input, 8): the byte stream from the STL UART client, little-endian packet order.
REQ-004 SHALL have tl_in_valid (output, 1) and tl_in_ready (input, 1): the frame handshake to the GenericSerializer.
REQ-005 SHALL have frame outputs tl_in_bits_chanId (3), tl_in_bits_opcode (3), tl_in_bits_param (3), tl_in_bits_size (8), tl_in_bits_source (8), tl_in_bits_address (64), tl_in_bits_data (64), tl_in_bits_corrupt (1) and tl_in_bits_union (9).
REQ-006 SHALL have timeout_count (output, 8): saturating count of partial packets discarded.

Function
REQ-007 SHALL use two states: COLLECT and PRESENT.
REQ-008 In COLLECT, rx_ready SHALL be 1; in PRESENT, rx_ready SHALL be 0.
REQ-009 A byte SHALL be accepted only when rx_valid and rx_ready are both 1, and stored at index byte_cnt (4-bit, 0..15); byte_cnt then increments.
REQ-010 On acceptance of byte 15, byte_cnt SHALL wrap to 0 and the state SHALL go to PRESENT; tl_in_valid SHALL rise on the next clk edge (1-cycle latency from the final byte handshake).
REQ-011 In PRESENT, tl_in_valid SHALL be 1 and all tl_in_bits_* SHALL hold stable until tl_in_valid and tl_in_ready are both 1; the state then returns to COLLECT and tl_in_valid falls on the next edge.
REQ-012 Unpacking rules:
- chanId = byte0[2:0]; byte0[7:3] ignored.
- opcode = byte1[2:0], param = byte1[6:4], corrupt = byte1[7]; byte1[3] ignored.
- size = byte2.
- union = {1'b0, byte3}.
- address = {32'h0, byte7..byte4} (byte4 is the LSB).
- data = byte15..byte8 (byte8 is the LSB).
- source = 8'h00.
REQ-013 While tl_in_valid is 0, the tl_in_bits_* SHALL retain the last presented frame (0 after reset).
REQ-014 tl_in_ready asserted in COLLECT SHALL have no effect.
REQ-015 Packets SHALL be back-to-back capable: at most one idle rx cycle (the PRESENT/accept cycle) per packet when tl_in_ready is held at 1.

Reset
REQ-016 async_reset_n low SHALL immediately force: state COLLECT, byte_cnt 0, tl_in_valid 0, all tl_in_bits_* 0, timeout_count 0, and the idle counter 0.
REQ-017 rx_ready SHALL be 1 from the first edge after reset deassertion.
REQ-018 Reset asserted mid-packet or in PRESENT SHALL discard the partial or pending frame; no frame is emitted after release until 16 new bytes arrive.

Configuration
REQ-019 With UART_TL_TIMEOUT_EN defined, an idle counter SHALL run in COLLECT while byte_cnt != 0 and no byte is accepted; it SHALL reset to 0 on every accepted byte.
REQ-020 With UART_TL_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT_CYCLES, byte_cnt and the idle counter SHALL clear to 0 and timeout_count SHALL increment, saturating at 255; a byte accepted in that same cycle SHALL be stored as byte 0 of a new packet.
REQ-021 With UART_TL_TIMEOUT_EN undefined, no idle counter SHALL exist, partial packets SHALL wait indefinitely, and timeout_count SHALL be tied to 0.

Verification
REQ-022 Scenario (packet decode): send bytes 03 A1 03 FF 78 56 34 12 EF CD AB 89 67 45 23 01 with tl_in_ready=1 -> one frame: chanId 3, opcode 1, param 2, corrupt 1, size 3, union 0x0FF, address 0x12345678, data 0x0123456789ABCDEF, source 0; tl_in_valid high exactly 1 cycle.
REQ-023 Scenario (backpressure): same packet with tl_in_ready=0 for 10 cycles -> tl_in_valid stays 1, fields stable, rx_ready 0 throughout, byte 0 of the next packet is not accepted before the handshake.
REQ-024 Scenario (streaming): three packets back-to-back, rx_valid and tl_in_ready constantly 1 -> three frames in order, 17 cycles apart.
REQ-025 Scenario (timeout, macro on, TIMEOUT_CYCLES=20): send 5 bytes, idle 20 cycles, then a full packet -> timeout_count=1 and exactly one frame, decoded from the full packet only.
REQ-026 Scenario (reset mid-packet): assert async_reset_n low between clk edges after byte 9 -> outputs clear without a clk edge; a subsequent full packet decodes correctly.
REQ-027 Scenario (macro off): send 5 bytes, idle 5000 cycles, then 11 bytes -> one frame from those 16 bytes; timeout_count 0.
